boot_copy_engine: RTL and testbench

BOOT_COPY_ENGINE -- requirements
Module: boot_copy_engine

---
 rtl/boot_copy_pkg.sv | 18 +
 rtl/boot_copy_engine.sv | 129 ++++++++++++
 tb/tb_boot_copy_engine.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_copy_pkg.sv
// Boot copy engine shared definitions.
// FSM state encoding, default widths and the write byte-enable constant.
package boot_copy_pkg;

   localparam int ROM_AW_DEF = 10;
   localparam int LEN_W_DEF  = 11;

   localparam logic [3:0] BE_ALL = 4'hF;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      CAPTURE = 3'd2,
      WRITE   = 3'd3,
      DONE    = 3'd4
   } bc_state_t;

endpackage

// File: rtl/boot_copy_engine.sv
// Boot copy engine: copies len words from boot ROM into RAM at 3 cycles/word.
// Optional checksum_o output enabled by defining BOOT_COPY_CHECKSUM_EN.
module boot_copy_engine
   import boot_copy_pkg::*;
#(
   parameter int ROM_AW = ROM_AW_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              start_i,
   input  logic [ROM_AW-1:0] src_i,
   input  logic [31:0]       dst_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              rom_csn_o,
   output logic [ROM_AW-1:0] rom_a_o,
   input  logic [31:0]       rom_q_i,
   output logic              mem_req_o,
   output logic [31:0]       mem_addr_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_be_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_gnt_i
`ifdef BOOT_COPY_CHECKSUM_EN
  ,output logic [31:0]       checksum_o
`endif
);

   bc_state_t         state_q;
   bc_state_t         state_d;
   logic [ROM_AW-1:0] src_q;
   logic [ROM_AW-1:0] rom_a_q;
   logic [31:0]       dst_q;
   logic [31:0]       wdata_q;
   logic [LEN_W-1:0]  cnt_q;
   logic              granted;

   assign granted = (state_q == WRITE) && mem_gnt_i;

   // State register; reset abandons any copy in flight.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state. Zero-length jobs pass through CAPTURE without loading
   // data so done_o appears two cycles after start with no accesses.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = (len_i != '0) ? FETCH : CAPTURE;
            end
         end
         FETCH:   state_d = CAPTURE;
         CAPTURE: state_d = (cnt_q != '0) ? WRITE : DONE;
         WRITE: begin
            if (mem_gnt_i) begin
               state_d = (cnt_q == LEN_W'(1)) ? DONE : FETCH;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Job registers: latch on start, read address on fetch, data on
   // capture, advance pointers and count on each granted write.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         rom_a_q <= '0;
         wdata_q <= '0;
      end else begin
         if (state_q == IDLE && start_i) begin
            src_q <= src_i;
            dst_q <= dst_i;
            cnt_q <= len_i;
         end
         if (state_q == FETCH) begin
            rom_a_q <= src_q;
         end
         if (state_q == CAPTURE && cnt_q != '0) begin
            wdata_q <= rom_q_i;
         end
         if (granted) begin
            src_q <= src_q + ROM_AW'(1);
            dst_q <= dst_q + 32'd4;
            cnt_q <= cnt_q - LEN_W'(1);
         end
      end
   end

`ifdef BOOT_COPY_CHECKSUM_EN
   logic [31:0] sum_q;

   // Wrapping sum of every granted write word, cleared on start.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         sum_q <= '0;
      end else if (state_q == IDLE && start_i) begin
         sum_q <= '0;
      end else if (granted) begin
         sum_q <= sum_q + wdata_q;
      end
   end

   assign checksum_o = sum_q;
`endif

   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign rom_csn_o   = (state_q != FETCH);
   assign rom_a_o     = (state_q == FETCH) ? src_q : rom_a_q;
   assign mem_req_o   = (state_q == WRITE);
   assign mem_addr_o  = dst_q;
   assign mem_we_o    = 1'b1;
   assign mem_be_o    = BE_ALL;
   assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_boot_copy_engine.sv
// Scoreboard bench for boot_copy_engine: ROM model, random grant, ref model.
// Checksum checks are built in when BOOT_COPY_CHECKSUM_EN is defined.
module tb_boot_copy_engine;

   localparam int AW = 10;
   localparam int LW = 11;

   logic          CLK = 1'b0;
   logic          RSTN = 1'b0;
   logic          start_i = 1'b0;
   logic [AW-1:0] src_i = '0;
   logic [31:0]   dst_i = '0;
   logic [LW-1:0] len_i = '0;
   logic          busy_o, done_o, rom_csn_o, mem_req_o, mem_we_o;
   logic [AW-1:0] rom_a_o;
   logic [31:0]   rom_q_i = '0;
   logic [31:0]   mem_addr_o, mem_wdata_o;
   logic [3:0]    mem_be_o;
   logic          mem_gnt_i = 1'b1;
`ifdef BOOT_COPY_CHECKSUM_EN
   logic [31:0]   checksum_o;
`endif

   boot_copy_engine #(.ROM_AW(AW), .LEN_W(LW)) dut (
      .CLK(CLK), .RSTN(RSTN), .start_i(start_i), .src_i(src_i),
      .dst_i(dst_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
      .rom_csn_o(rom_csn_o), .rom_a_o(rom_a_o), .rom_q_i(rom_q_i),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i)
`ifdef BOOT_COPY_CHECKSUM_EN
     ,.checksum_o(checksum_o)
`endif
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int stalls = 0;
   int gmode = 0;
   int stall_left = 0;

   logic [31:0] rom [0:1023];
   logic [31:0] exp_addr [$];
   logic [31:0] exp_data [$];
   int          exp_rom [$];

   logic        held = 1'b0;
   logic [31:0] held_addr = '0;
   logic [31:0] held_data = '0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // Synchronous ROM: data valid the cycle after chip select.
   always @(posedge CLK) begin
      if (!rom_csn_o) rom_q_i <= rom[rom_a_o];
   end

   // Grant driver: tied high, random, or withheld for stall_left cycles.
   initial forever begin
      @(posedge CLK);
      #1;
      if (gmode == 2 && stall_left > 0 && mem_req_o) begin
         mem_gnt_i = 1'b0;
         stall_left--;
      end else if (gmode == 1) begin
         mem_gnt_i = 1'($urandom_range(0, 1));
      end else begin
         mem_gnt_i = 1'b1;
      end
   end

   // Monitor: pops expected ROM reads and RAM writes as they appear.
   initial forever begin
      @(negedge CLK);
      if (RSTN) begin
         if (!rom_csn_o) begin
            if (exp_rom.size() == 0) begin
               chk("rom_unexpected", 64'(rom_a_o), 64'hFFFF);
            end else begin
               chk("rom_addr", 64'(rom_a_o), 64'(exp_rom.pop_front()));
            end
         end
         if (held) begin
            chk("stall_req", 64'(mem_req_o), 64'd1);
            chk("stall_addr", 64'(mem_addr_o), 64'(held_addr));
            chk("stall_data", 64'(mem_wdata_o), 64'(held_data));
         end
         if (mem_req_o) begin
            chk("csn_in_write", 64'(rom_csn_o), 64'd1);
            if (mem_gnt_i) begin
               if (exp_addr.size() == 0) begin
                  chk("wr_unexpected", 64'(mem_addr_o), 64'hFFFF_FFFF_FFFF);
               end else begin
                  chk("wr_addr", 64'(mem_addr_o), 64'(exp_addr.pop_front()));
                  chk("wr_data", 64'(mem_wdata_o), 64'(exp_data.pop_front()));
                  chk("wr_we_be", 64'({mem_we_o, mem_be_o}), 64'h1F);
               end
            end else begin
               stalls++;
            end
         end
         held      = mem_req_o && !mem_gnt_i;
         held_addr = mem_addr_o;
         held_data = mem_wdata_o;
      end else begin
         held = 1'b0;
      end
   end

   // One job: queue expectations, pulse start, wait for done, check timing.
   task automatic do_copy(input logic [AW-1:0] s, input logic [31:0] d,
                          input int n, input int poke, input int exp_lat);
      int          t0;
      int          want;
      bit          seen;
      logic [31:0] sum;
      sum = '0;
      for (int i = 0; i < n; i++) begin
         exp_rom.push_back((int'(s) + i) % 1024);
         exp_addr.push_back(d + 32'(4 * i));
         exp_data.push_back(rom[(int'(s) + i) % 1024]);
         sum = sum + rom[(int'(s) + i) % 1024];
      end
      @(posedge CLK);
      #2;
      stalls  = 0;
      start_i = 1'b1;
      src_i   = s;
      dst_i   = d;
      len_i   = LW'(n);
      t0      = cyc;
      @(posedge CLK);
      #2;
      start_i = 1'b0;
      src_i   = AW'($urandom);
      dst_i   = $urandom;
      len_i   = LW'($urandom_range(1, 9));
      chk("busy_after_start", 64'(busy_o), 64'd1);
      seen = 1'b0;
      for (int k = 0; k < 4000 && !seen; k++) begin
         @(negedge CLK);
         start_i = (poke > 0 && cyc == t0 + poke);
         if (done_o) seen = 1'b1;
      end
      start_i = 1'b0;
      if (!seen) begin
         chk("done_timeout", 64'd0, 64'd1);
      end else begin
         want = (exp_lat >= 0) ? exp_lat :
                (n == 0) ? 2 : 1 + 3 * n + stalls;
         chk("done_latency", 64'(cyc - t0), 64'(want));
`ifdef BOOT_COPY_CHECKSUM_EN
         chk("checksum", 64'(checksum_o), 64'(sum));
`endif
      end
      chk("wr_left", 64'(exp_addr.size()), 64'd0);
      chk("rom_left", 64'(exp_rom.size()), 64'd0);
      @(negedge CLK);
      chk("busy_after_done", 64'(busy_o), 64'd0);
      chk("done_one_cycle", 64'(done_o), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = $urandom;
      for (int i = 32; i < 36; i++) rom[i] = 32'(i);
      rom[10'h100] = 32'h0000_0001;
      rom[10'h101] = 32'h0000_0002;
      rom[10'h102] = 32'hFFFF_FFFF;

      repeat (3) @(posedge CLK);
      #2;
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_csn", 64'(rom_csn_o), 64'd1);
      chk("rst_rom_a", 64'(rom_a_o), 64'd0);
      chk("rst_req", 64'(mem_req_o), 64'd0);
      chk("rst_addr", 64'(mem_addr_o), 64'd0);
      chk("rst_wdata", 64'(mem_wdata_o), 64'd0);
`ifdef BOOT_COPY_CHECKSUM_EN
      chk("rst_checksum", 64'(checksum_o), 64'd0);
`endif
      @(negedge CLK);
      RSTN = 1'b1;

      gmode = 0;
      do_copy(10'h020, 32'h0010_0000, 4, 0, 13);

      gmode      = 2;
      stall_left = 5;
      do_copy(10'h040, 32'h0020_0000, 2, 0, 12);
      gmode = 0;

      do_copy(10'h3FF, 32'h0030_0000, 2, 0, 7);
      do_copy(10'h123, 32'h0040_0000, 0, 0, 2);

      do_copy(10'h100, 32'h0050_0000, 3, 4, 10);
`ifdef BOOT_COPY_CHECKSUM_EN
      chk("checksum_wrap", 64'(checksum_o), 64'h2);
`endif

      gmode      = 2;
      stall_left = 1000;
      exp_rom.push_back(32'h200);
      @(posedge CLK);
      #2;
      start_i = 1'b1;
      src_i   = 10'h200;
      dst_i   = 32'h0060_0000;
      len_i   = LW'(6);
      @(posedge CLK);
      #2;
      start_i = 1'b0;
      for (int k = 0; k < 50 && !mem_req_o; k++) @(negedge CLK);
      chk("reached_write", 64'(mem_req_o), 64'd1);
      #1;
      RSTN = 1'b0;
      #1;
      chk("arst_busy", 64'(busy_o), 64'd0);
      chk("arst_req", 64'(mem_req_o), 64'd0);
      chk("arst_csn", 64'(rom_csn_o), 64'd1);
      chk("arst_addr", 64'(mem_addr_o), 64'd0);
      chk("arst_wdata", 64'(mem_wdata_o), 64'd0);
      exp_rom.delete();
      exp_addr.delete();
      exp_data.delete();
      gmode      = 0;
      stall_left = 0;
      @(negedge CLK);
      RSTN = 1'b1;
      do_copy(10'h020, 32'h0070_0000, 4, 0, 13);

      gmode = 1;
      for (int t = 0; t < 12; t++) begin
         do_copy(AW'($urandom), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                 $urandom_range(0, 6), $urandom_range(0, 1) * 2, -1);
      end
      gmode = 0;
      do_copy(10'h3FE, 32'hFFFF_FFF8, 4, 0, 13);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
